// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a 4-beat line fill.
// Define DCACHE_STATS_EN to add read hit/miss counters (read_hits, read_misses).
module l1_dcache #(
  parameter int ADDR_W  = 30,
  parameter int INDEX_W = 6,
  parameter int OFF_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ren,
  input  logic              wen,
  input  logic [3:0]        byte_select_vector,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       read_hits,
  output logic [31:0]       read_misses
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFF_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [OFF_W-1:0]          beat_q;
  logic [LINES-1:0]          valid_q;
  logic [TAG_W-1:0]          tag_q  [LINES];
  logic [WORDS-1:0][31:0]    data_q [LINES];

  logic [TAG_W-1:0]   tag_f;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;
  logic               hit, fill_beat, fill_last, wr_hit;

  assign tag_f = addr[ADDR_W-1 -: TAG_W];
  assign idx   = addr[OFF_W +: INDEX_W];
  assign off   = addr[OFF_W-1:0];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag_f);
  assign dout  = data_q[idx][off];

  assign fill_beat = (state_q == FILL) && mem_ready;
  assign fill_last = fill_beat && (beat_q == '1);
  assign wr_hit    = (state_q == WRITE) && mem_ready && hit;

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        // wen wins over ren when both are (illegally) raised
        if (wen) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (ren && !hit) begin
          stall   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag_f, idx, beat_q};
        if (fill_last) state_d = IDLE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = din;
        mem_be    = byte_select_vector;
        stall     = !mem_ready;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_beat) beat_q <= beat_q + 1'b1;
      if (fill_last) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid_q alone guards it.
  always_ff @(posedge clock) begin
    if (fill_beat) data_q[idx][beat_q] <= mem_rdata;
    if (fill_last) tag_q[idx] <= tag_f;
    if (wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (byte_select_vector[b]) data_q[idx][off][8*b +: 8] <= din[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  logic just_filled_q;

  // The retry cycle after a fill is the tail of a miss, not a fresh hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      just_filled_q <= 1'b0;
      read_hits     <= '0;
      read_misses   <= '0;
    end else begin
      just_filled_q <= fill_last;
      if (state_q == IDLE && state_d == FILL) read_misses <= read_misses + 1'b1;
      if (state_q == IDLE && ren && hit && !just_filled_q) read_hits <= read_hits + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: backing-memory responder with a scoreboard of expected
// memory transactions, plus per-scenario tasks checking stall/dout timing.
module tb_l1_dcache;
  localparam int ADDR_W = 30;

  logic              clock = 1'b0;
  logic              reset;
  logic              ren, wen;
  logic [3:0]        byte_select_vector;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din, dout;
  logic              stall, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]       read_hits, read_misses;
`endif

  l1_dcache dut (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen),
    .byte_select_vector(byte_select_vector), .addr(addr), .din(din), .dout(dout),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .read_hits(read_hits), .read_misses(read_misses)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       wd;
  } txn_t;

  txn_t        sb[$];
  txn_t        cur;
  logic [31:0] mem_model [int];
  int          errors = 0;
  int          checks = 0;
  int          gap = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_read(input logic [ADDR_W-1:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    if (a[ADDR_W-1:2] == 4) return 32'hCAFE0000 + {30'd0, a[1:0]};
    return 32'hA5000000 ^ {2'b00, a};
  endfunction

  function automatic txn_t rd_txn(input logic [ADDR_W-1:0] a);
    txn_t t;
    t.we = 1'b0; t.a = a; t.be = 4'b0; t.wd = 32'd0;
    return t;
  endfunction

  // Ready/data decision made just after the edge so it is stable all cycle.
  always @(posedge clock) begin
    #1;
    if (reset && mem_req) begin
      if (wait_cnt >= gap) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  // A beat completes on the next rising edge; compare it against the scoreboard now.
  always @(negedge clock) begin
    if (reset && mem_req && mem_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_txn we=%0b addr=%h (none expected)", mem_we, mem_addr);
      end else begin
        cur = sb.pop_front();
        if (mem_we !== cur.we || mem_addr !== cur.a ||
            (cur.we && (mem_be !== cur.be || mem_wdata !== cur.wd))) begin
          errors++;
          $display("FAIL mem_txn got we=%0b addr=%h be=%b wd=%h want we=%0b addr=%h be=%b wd=%h",
                   mem_we, mem_addr, mem_be, mem_wdata, cur.we, cur.a, cur.be, cur.wd);
        end
      end
      if (mem_we) begin
        cur.wd = mem_read(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) cur.wd[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_model[int'(mem_addr)] = cur.wd;
      end
    end
  end

  task automatic drive_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                            input int exp_stall, input string nm);
    int n = 0;
    bit done = 0;
    @(posedge clock); #1;
    ren = 1'b1; addr = a;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (stall) n++; else done = 1;
    end
    checks++;
    if (!done || n != exp_stall) begin
      errors++;
      $display("FAIL %s_stall_cycles got %0d want %0d (done=%0b)", nm, n, exp_stall, done);
    end
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s_dout got %h want %h", nm, dout, exp);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_mem_req_on_hit got %b want 0", nm, mem_req);
    end
    @(posedge clock); #1;
    ren = 1'b0;
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [3:0] be,
                             input logic [31:0] d, input int exp_stall, input string nm);
    int n = 0;
    bit done = 0;
    @(posedge clock); #1;
    wen = 1'b1; addr = a; byte_select_vector = be; din = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (stall) n++; else done = 1;
    end
    checks++;
    if (!done || n != exp_stall) begin
      errors++;
      $display("FAIL %s_stall_cycles got %0d want %0d (done=%0b)", nm, n, exp_stall, done);
    end
    @(posedge clock); #1;
    wen = 1'b0;
  endtask

  task automatic sb_drained(input string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_drained got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
    byte_select_vector = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== '0 || mem_be !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b req=%b we=%b addr=%h be=%b want all 0",
               stall, mem_req, mem_we, mem_addr, mem_be);
    end
`ifdef DCACHE_STATS_EN
    checks++;
    if (read_hits !== 0 || read_misses !== 0) begin
      errors++;
      $display("FAIL reset_stats got hits=%0d misses=%0d want 0/0", read_hits, read_misses);
    end
`endif
  endtask

  task automatic test_cold_miss;
    gap = 0;
    for (int b = 0; b < 4; b++) sb.push_back(rd_txn(ADDR_W'(32'h10 + b)));
    drive_read(30'h10, 32'hCAFE0000, 5, "cold_miss");
    sb_drained("cold_miss");
  endtask

  task automatic test_read_hit;
    drive_read(30'h12, 32'hCAFE0002, 0, "read_hit");
    sb_drained("read_hit");
`ifdef DCACHE_STATS_EN
    checks++;
    if (read_hits !== 1 || read_misses !== 1) begin
      errors++;
      $display("FAIL stats_after_hit got hits=%0d misses=%0d want 1/1", read_hits, read_misses);
    end
`endif
  endtask

  task automatic test_write_hit;
    txn_t t;
    gap = 1;
    t.we = 1'b1; t.a = 30'h11; t.be = 4'b0011; t.wd = 32'h0000BEEF;
    sb.push_back(t);
    drive_write(30'h11, 4'b0011, 32'h0000BEEF, 2, "write_hit");
    sb_drained("write_hit");
    gap = 0;
    drive_read(30'h11, 32'hCAFEBEEF, 0, "write_hit_readback");
    sb_drained("write_hit_readback");
  endtask

  task automatic test_write_miss;
    txn_t t;
    gap = 0;
    t.we = 1'b1; t.a = 30'h200; t.be = 4'b1111; t.wd = 32'h12345678;
    sb.push_back(t);
    drive_write(30'h200, 4'b1111, 32'h12345678, 1, "write_miss");
    for (int b = 0; b < 4; b++) sb.push_back(rd_txn(ADDR_W'(32'h200 + b)));
    drive_read(30'h200, 32'h12345678, 5, "write_miss_no_alloc");
    sb_drained("write_miss");
  endtask

  task automatic test_conflict;
    gap = 0;
    for (int b = 0; b < 4; b++) sb.push_back(rd_txn(ADDR_W'(32'h110 + b)));
    drive_read(30'h110, 32'hA5000000 ^ 32'h110, 5, "conflict_fill");
    for (int b = 0; b < 4; b++) sb.push_back(rd_txn(ADDR_W'(32'h10 + b)));
    drive_read(30'h10, 32'hCAFE0000, 5, "conflict_evict");
    sb_drained("conflict");
  endtask

  task automatic test_reset_mid_fill;
    gap = 0;
    sb.push_back(rd_txn(30'h110));
    sb.push_back(rd_txn(30'h111));
    @(posedge clock); #1;
    ren = 1'b1; addr = 30'h110;
    repeat (3) @(negedge clock);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill_req got req=%b addr=%h want 0/0", mem_req, mem_addr);
    end
    sb_drained("reset_mid_fill");
`ifdef DCACHE_STATS_EN
    checks++;
    if (read_hits !== 0 || read_misses !== 0) begin
      errors++;
      $display("FAIL reset_mid_fill_stats got hits=%0d misses=%0d want 0/0", read_hits, read_misses);
    end
`endif
    ren = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int b = 0; b < 4; b++) sb.push_back(rd_txn(ADDR_W'(32'h10 + b)));
    drive_read(30'h10, 32'hCAFE0000, 5, "refill_after_reset");
    sb_drained("refill_after_reset");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_fill();
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-through, no-write-allocate L1 data cache. It sits between the pipelined core's MEM stage (the request side: ren/wen/byte-select/word address/write data) and a slower backing data memory. Read hits return data in the request cycle. Misses and all writes raise `stall` until the backing memory completes the transfer over a ready-based request port.

## Interface
- `ADDR_W`, 30: CPU word-address width.
- `INDEX_W`, 6: set index bits (64 lines).
- `OFF_W`, 2: word-offset bits (4 words/line).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ren` in 1: CPU read request.
- `wen` in 1: CPU write request.
- `byte_select_vector` in 4: write byte enables, active high; `din` is already lane-aligned.
- `addr` in ADDR_W: CPU word address. Fields are {tag, index[INDEX_W], offset[OFF_W]}.
- `din` in 32: CPU write data.
- `dout` out 32: read data.
- `stall` out 1: CPU must hold its request stable and freeze.
- `mem_req` out 1: backing memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: backing word address.
- `mem_wdata` out 32: backing write data.
- `mem_be` out 4: backing byte enables.
- `mem_rdata` in 32: backing read data, valid with `mem_ready`.
- `mem_ready` in 1: completes one beat; ignored while `mem_req` = 0.

## Operation
- Arrays: valid bits are flops cleared by reset. Tag and data arrays have no reset.
- States and transitions:
  - IDLE → FILL: `ren` & miss.
  - IDLE → WRITE: `wen`. `wen` has priority if `ren` & `wen` are both high (illegal input).
  - FILL → IDLE: beat 3 completes.
  - WRITE → IDLE: `mem_ready`.
- IDLE:
  - `hit` = valid[index] & tag match.
  - `stall` = (`ren` & !hit) | `wen`.
  - `dout` = data[index][offset] combinationally, regardless of hit.
- FILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, beat}.
  - Beat counter runs 0..3; there is no critical-word-first.
  - Each `mem_ready` writes `mem_rdata` into data[index][beat] and increments beat.
  - On beat 3: tag is written, valid is set, go to IDLE.
  - `stall`=1 throughout. The retried read then hits in IDLE.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=`din`, `mem_be`=`byte_select_vector`.
  - `stall` = !`mem_ready`, so the CPU advances on the completing edge.
  - On a hit at that edge, enabled bytes are merged into the line.
  - On a miss, no allocation is made.
- `mem_req` is held with a stable address and data until `mem_ready`.
- Reset mid-operation: FSM returns to IDLE, `mem_req` drops immediately, beat is cleared, all valid bits are cleared. A partially filled line is never marked valid.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, beat 0. `stall` is 0 while `ren`/`wen` are low.
- Read hit latency: 0 cycles (combinational, same cycle).
- Read miss: 1 IDLE cycle, then 4 beats (each ≥1 cycle), then 1 IDLE hit cycle. Minimum is 6 cycles with `stall` high for the first 5.
- Write: 1 IDLE cycle plus ≥1 WRITE cycle. Minimum is 2 cycles with `stall` high for 1.
- `mem_ready` with `mem_req` low has no effect. Back-to-back `mem_ready` completes one beat per cycle.
- `stall`, `dout`, and `hit` are combinational. All state updates occur on the rising edge.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `read_hits` [31:0] and `read_misses` [31:0], both reset to 0 and wrapping.
  - `read_misses` increments on IDLE→FILL.
  - `read_hits` increments on IDLE `ren` & hit cycles, except the first IDLE cycle following a FILL (tracked by a 1-bit `just_filled` flop).
- Undefined: the counters, the `just_filled` flop, and both ports are absent. All other behaviour is identical.

## Test plan
- Cold read miss:
  - Stimulus: after reset, `ren` `addr`=0x10. Memory returns 0xCAFE0000+beat with `mem_ready` every cycle.
  - Response: `mem_addr` 0x10,0x11,0x12,0x13; `stall` high 5 cycles; then `dout`=0xCAFE0000 with `stall`=0.
- Read hit: following that, `ren` `addr`=0x12 → `stall`=0 same cycle, `dout`=0xCAFE0002, `mem_req`=0.
- Write hit merge:
  - Stimulus: `wen` `addr`=0x11, bse=4'b0011, `din`=0x0000BEEF, `mem_ready` on the 2nd WRITE cycle.
  - Response: `stall` high 2 cycles; `mem_be`=0011; a subsequent read of 0x11 gives 0xCAFEBEEF with no `mem_req`.
- Write miss, no allocation: `wen` `addr`=0x200 → one memory write. A following `ren` 0x200 misses with 4 fill beats at 0x200..0x203.
- Conflict eviction: read 0x110 (same index 4, tag 1) fills. A read of 0x10 then misses again.
- Reset mid-fill: drop `reset` after 2 beats → `mem_req`=0 immediately. After release, a read of 0x10 misses and refills. With `DCACHE_STATS_EN`, counters read 0 after reset.
